icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache_if.sv | 22 ++
 rtl/icache.sv | 121 ++++++++++++
 2 files changed

// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle for the icache.
// slave = cache view, master = datapath/memory environment view.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped one-word-line instruction cache: zero-cycle hits, one outstanding fill.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]       state;
  logic [31:0]      fillAddr;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tagArr  [SETS];
  logic [31:0]      dataArr [SETS];

  logic [IDX_W-1:0] reqIdx;
  logic [IDX_W-1:0] fillIdx;
  logic [TAG_W-1:0] reqTag;
  logic [TAG_W-1:0] fillTag;
  logic             lookupHit;
  logic             missReq;
  logic             fillDone;
  logic             fwdHit;
  logic             unusedAddrBits;

  assign reqIdx  = bus.imemaddr[IDX_W+1:2];
  assign reqTag  = bus.imemaddr[31:IDX_W+2];
  assign fillIdx = fillAddr[IDX_W+1:2];
  assign fillTag = fillAddr[31:IDX_W+2];
  assign unusedAddrBits = ^bus.imemaddr[1:0];

  assign lookupHit = (state == IDLE) && bus.imemREN && valid[reqIdx] &&
                     (tagArr[reqIdx] == reqTag);
  assign missReq   = (state == IDLE) && bus.imemREN && !lookupHit;
  assign fillDone  = (state == FILL) && !bus.iwait;
  // Forward only when the datapath is still asking for the word being filled.
  assign fwdHit    = fillDone && bus.imemREN && (bus.imemaddr[31:2] == fillAddr[31:2]);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      fillAddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (missReq) begin
            state    <= FILL;
            fillAddr <= {bus.imemaddr[31:2], 2'b00};
          end
        end
        FILL: begin
          if (!bus.iwait) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
    end else if (fillDone) begin
      valid[fillIdx] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; validity alone gates its use.
  always_ff @(posedge CLK) begin
    if (fillDone) begin
      tagArr[fillIdx]  <= fillTag;
      dataArr[fillIdx] <= bus.iload;
    end
  end

  always_comb begin
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    if (state == FILL) begin
      bus.iREN  = 1'b1;
      bus.iaddr = fillAddr;
    end
    if (lookupHit) begin
      bus.ihit     = 1'b1;
      bus.imemload = dataArr[reqIdx];
    end else if (fwdHit) begin
      bus.ihit     = 1'b1;
      bus.imemload = bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (lookupHit) hit_count  <= satInc(hit_count);
      if (missReq)   miss_count <= satInc(miss_count);
    end
  end
`endif

endmodule
